// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider slice.
package div_pkg;

  // Operand width shared by the Remainder register, ALU and divisor register.
  localparam int DIV_WIDTH = 32;

  // Controller state encoding.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_iter_counter.sv
// Iteration counter for the shift/subtract phase: synchronous clear,
// count enable, and a terminal flag on the last iteration.
module div_iter_counter #(
  parameter int WIDTH = div_pkg::DIV_WIDTH,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CNT_W-1:0] cnt;

  // Count iterations; clear has priority so each run starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign term = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/divider_control.sv
// Moore FSM sequencing the restoring divider: one init cycle, WIDTH
// shift/subtract iterations, one high-half right-shift, then hold with Ready.
module divider_control
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Divisor_in,
  output logic             Rem_init,
  output logic             Divisor_W,
  output logic             W_ctrl,
  output logic             SLL_ctrl,
  output logic             SRL_ctrl,
  output logic             Ready,
  output logic             Busy,
  output logic             Div_zero
);

  div_state_t state_q, state_d;
  logic       cnt_term;
  logic       accept;
  logic       zero_div;

  div_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk  (clk),
    .rst  (Reset),
    .clr  (state_q == INIT),
    .en   ((state_q == RUN) && !cnt_term),
    .term (cnt_term)
  );

  // State register; Reset abandons any division in progress.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divide-by-zero flag, updated only when a Start is accepted.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      Div_zero <= 1'b0;
    end else if (accept) begin
      Div_zero <= zero_div;
    end
  end

  // Next-state logic and Moore output decode from the registered state.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    zero_div  = (Divisor_in == '0);
    Rem_init  = 1'b0;
    Divisor_W = 1'b0;
    W_ctrl    = 1'b0;
    SLL_ctrl  = 1'b0;
    SRL_ctrl  = 1'b0;
    Ready     = 1'b0;
    Busy      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        Ready = (state_q == DONE);
        if (Start) begin
          accept  = 1'b1;
          state_d = zero_div ? DONE : INIT;
        end
      end
      INIT: begin
        Rem_init  = 1'b1;
        Divisor_W = 1'b1;
        W_ctrl    = 1'b1;
        SLL_ctrl  = 1'b1;
        Busy      = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        W_ctrl   = 1'b1;
        SLL_ctrl = 1'b1;
        Busy     = 1'b1;
        if (cnt_term) begin
          state_d = FIX;
        end
      end
      FIX: begin
        W_ctrl   = 1'b1;
        SRL_ctrl = 1'b1;
        Busy     = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_divider_control.sv
// Directed bench for divider_control: reset, nominal timing, back-to-back,
// divide-by-zero, Start while busy, and asynchronous reset mid-run.
module tb_divider_control;

  logic        clk;
  logic        Reset;
  logic        Start;
  logic [31:0] Divisor_in;
  logic        Rem_init, Divisor_W, W_ctrl, SLL_ctrl, SRL_ctrl;
  logic        Ready, Busy, Div_zero;

  int vectors     = 0;
  int miscompares = 0;

  divider_control #(.WIDTH(32)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Start      (Start),
    .Divisor_in (Divisor_in),
    .Rem_init   (Rem_init),
    .Divisor_W  (Divisor_W),
    .W_ctrl     (W_ctrl),
    .SLL_ctrl   (SLL_ctrl),
    .SRL_ctrl   (SRL_ctrl),
    .Ready      (Ready),
    .Busy       (Busy),
    .Div_zero   (Div_zero)
  );

  // Rising edges at 10, 20, 30 ...; sampling happens on falling edges.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Output bundle order: {Rem_init, Divisor_W, W_ctrl, SLL_ctrl, SRL_ctrl, Ready, Busy, Div_zero}
  function automatic logic [7:0] outs();
    return {Rem_init, Divisor_W, W_ctrl, SLL_ctrl, SRL_ctrl, Ready, Busy, Div_zero};
  endfunction

  // Expected outputs k edges after the Start-sampling edge E0 (sampled after Ek).
  function automatic logic [7:0] exp_nominal(input int k, input logic dz);
    if (k == 0)       return {7'b1111001, dz};  // INIT
    else if (k <= 32) return {7'b0011001, dz};  // RUN, 32 cycles
    else if (k == 33) return {7'b0010101, dz};  // FIX
    else              return {7'b0000010, dz};  // DONE
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Issue Start with divisor d, then check k=0..last_k; inj>=0 raises Start again after Ek.
  task automatic do_div(input string name, input logic [31:0] d, input int last_k,
                        input int inj, input logic dz, input logic zero_case);
    @(negedge clk);
    Start      = 1'b1;
    Divisor_in = d;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      if (zero_case)
        check($sformatf("%s k=%0d", name, k), outs(), {7'b0000010, 1'b1});
      else
        check($sformatf("%s k=%0d", name, k), outs(), exp_nominal(k, dz));
      Start = (k == inj);
    end
    Start = 1'b0;
  endtask

  initial begin
    Reset      = 1'b1;
    Start      = 1'b0;
    Divisor_in = 32'd0;
    #1;
    check("reset_held", outs(), 8'h00);
    #14;
    Reset = 1'b0;
    // Idle with no Start through t=100.
    while ($time < 100) begin
      @(negedge clk);
      check($sformatf("idle t=%0t", $time), outs(), 8'h00);
    end

    // Nominal 32-bit division by 10: Ready 34 edges after Start.
    do_div("nominal", 32'd10, 36, -1, 1'b0, 1'b0);

    // Back-to-back from DONE: Ready drops the cycle after Start.
    do_div("b2b", 32'd7, 35, -1, 1'b0, 1'b0);

    // Divide by zero: straight to DONE with Div_zero, no write pulses.
    do_div("divzero", 32'd0, 4, -1, 1'b1, 1'b1);

    // Valid divisor clears Div_zero; Start at iteration 5 is ignored.
    do_div("busy_start", 32'd10, 35, 5, 1'b0, 1'b0);

    // Divide by zero again, then reset clears Div_zero.
    do_div("divzero2", 32'd0, 1, -1, 1'b1, 1'b1);
    #2 Reset = 1'b1;
    #1 check("reset_dz", outs(), 8'h00);
    @(negedge clk);
    Reset = 1'b0;

    // Reset asserted mid-RUN: outputs drop immediately, before any edge.
    do_div("midrun", 32'd3, 10, -1, 1'b0, 1'b0);
    #2 Reset = 1'b1;
    #1 check("midrun_reset_async", outs(), 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midrun_reset_hold %0d", i), outs(), 8'h00);
    end
    Reset = 1'b0;
    @(negedge clk);
    check("after_reset_idle", outs(), 8'h00);
    @(negedge clk);
    check("after_reset_idle2", outs(), 8'h00);

    // Full division after the abandoned one still has nominal timing.
    do_div("recover", 32'd10, 35, -1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/divider_control.md
Name: divider_control

Overview:
- FSM controller for the sequential restoring divider. It sits directly upstream of the Remainder register and drives its SLL_ctrl, SRL_ctrl, W_ctrl, Ready and init (Reset-port) controls.
- It sequences one init cycle, WIDTH shift/subtract iterations and one final high-half right-shift, then holds the result with Ready.
- It also strobes the divisor register load and detects divide-by-zero at start.

Parameters:
- WIDTH, 32, operand width; also the number of shift/subtract iterations.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high controller reset.
- Start  input  1  one-cycle request to begin a division; sampled only in IDLE or DONE.
- Divisor_in  input  WIDTH  divisor operand; checked for zero when Start is accepted.
- Rem_init  output  1  connects to the Remainder register's Reset input; loads Dividend_in<<1.
- Divisor_W  output  1  write enable of the divisor register.
- W_ctrl  output  1  Remainder write enable.
- SLL_ctrl  output  1  Remainder shift-left/subtract-step select.
- SRL_ctrl  output  1  Remainder high-half right-shift select.
- Ready  output  1  result valid; freezes the Remainder outputs.
- Busy  output  1  division in progress (INIT, RUN or FIX).
- Div_zero  output  1  last accepted division had Divisor_in == 0.

Behaviour:
- Async Reset=1: state=IDLE, counter=0. All outputs are 0 immediately and stay 0 while Reset is held. This includes a mid-operation Reset; the partial Remainder contents are abandoned.
- Outputs are Moore (registered state decode); none depend combinationally on Start.
- States:
  - IDLE: all outputs 0.
  - INIT: Rem_init=1, W_ctrl=1, SLL_ctrl=1, Divisor_W=1, Busy=1.
  - RUN: W_ctrl=1, SLL_ctrl=1, Busy=1.
  - FIX: W_ctrl=1, SRL_ctrl=1, SLL_ctrl=0, Busy=1.
  - DONE: Ready=1; W_ctrl, SLL_ctrl, SRL_ctrl=0.
- Transitions:
  - IDLE/DONE + Start + Divisor_in!=0 -> INIT. Div_zero<=0, Ready drops the next cycle.
  - IDLE/DONE + Start + Divisor_in==0 -> DONE. Div_zero<=1, Ready=1 the next cycle; no W_ctrl or Divisor_W pulse, so Remainder contents are unchanged.
  - INIT -> RUN, counter<=0.
  - RUN: counter increments each cycle; at counter==WIDTH-1 -> FIX. RUN therefore lasts exactly WIDTH cycles.
  - FIX -> DONE.
  - DONE holds indefinitely (Ready=1) until Start.
- Latency: the Start-sampling edge is E0. INIT runs E0->E1, RUN E1->E(WIDTH+1), FIX one cycle. Ready=1 after edge E(WIDTH+2), i.e. 34 edges for WIDTH=32.
- Start while Busy=1 is ignored: no restart, no queuing.
- Start in DONE on the same edge that Ready would persist: Start wins, and Ready=0 the next cycle.
- Div_zero holds its value until the next accepted Start.
- The counter never wraps within a run; it is cleared in INIT.
- Exactly one of SLL_ctrl / SRL_ctrl is high whenever W_ctrl=1; both are 0 when W_ctrl=0.
- The controller does not use ALU_carry. The quotient bit (~carry) is inserted by the Remainder register.

Decomposition:
- Package div_pkg holds:
  - the state typedef / localparams (IDLE=0, INIT=1, RUN=2, FIX=3, DONE=4, 3-bit encoding);
  - DIV_WIDTH=32, shared with Remainder, ALU and divisor register.
- One sub-module, div_iter_counter: clear, enable, CNT_W-bit count, and a terminal flag at WIDTH-1. The FSM stays in divider_control.

Test Plan:
- Reset then idle: Reset=1 at t=0, released at 15 with Start=0 -> all outputs 0 through t=100. Reset asserted mid-RUN (iteration 10) -> all outputs 0 in the same cycle, state=IDLE.
- Nominal sequence: Start pulse with Divisor_in=10 -> Rem_init=1 for exactly 1 cycle, SLL_ctrl=W_ctrl=1 for 33 cycles (INIT+RUN), SRL_ctrl=1 for 1 cycle, then Ready=1 34 edges after Start.
- Integrated with Remainder + ALU: Dividend_in=0xFFFF_FFFF, Divisor_in=10 -> at Ready, Remainder_out={32'd5, 32'h1999_9999}. Also 100/7 -> {32'd2, 32'd14}.
- Divide-by-zero: Start with Divisor_in=0 -> next cycle Ready=1, Div_zero=1, and W_ctrl/Divisor_W never pulse.
- Start during Busy (at iteration 5) -> ignored; Ready timing is identical to the nominal case.
- Back-to-back: Start issued in DONE -> Ready=0 the next cycle and the second division completes 34 edges later. Div_zero is cleared on a valid divisor.
